// File: rtl/oreg_arbiter_pkg.sv
// oreg_arbiter_defs: shared widths and FSM encoding for the oreg bus arbiter
package oreg_arbiter_defs;
  localparam int InstWidth = 12;
  localparam int WenWidth  = 8;
  localparam int CntWidth  = 8;
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;
endpackage

// File: rtl/oreg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid requester after the pointer
//   i_valid   requests to choose from
//   i_pointer last winner; the scan starts at i_pointer+1 and wraps
//   o_pick    one-hot winner, o_index its index, o_any high when any is valid
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_valid,
  input  logic [$clog2(N)-1:0] i_pointer,
  output logic [N-1:0]         o_pick,
  output logic [$clog2(N)-1:0] o_index,
  output logic                 o_any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_j;
  always_comb begin
    o_pick  = '0;
    o_index = '0;
    o_any   = 1'b0;
    w_j     = '0;
    // scan farthest first so the nearest valid requester after the pointer is the final write
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_pointer) + k) % N);
      if (i_valid[w_j]) begin
        o_pick  = N'(1) << w_j;
        o_index = w_j;
        o_any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/oreg_arbiter.sv
// oreg_arbiter: round-robin arbiter sharing one registered peripheral instruction bus
//   clock, reset          single clock, async active-high reset
//   req_valid/inst/wen    per-requester transfer offer (12-bit word, 8-bit strobes)
//   req_lock              hold the bus for the offering requester after this transfer
//   req_ready             combinational accept, at most one bit high
//   inst, inst_en, grant  registered bus word, one-cycle strobes, last accepted owner
//   lock_timeout          one-cycle pulse when an idle owner loses its lock
//   OREG_ARBITER_STATS_EN adds contention (8b) and timeouts (4b) saturating counters
module oreg_arbiter
  import oreg_arbiter_defs::*;
#(
  parameter int NrReq       = 2,
  parameter int LockTimeout = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NrReq-1:0]          req_valid,
  input  logic [InstWidth*NrReq-1:0] req_inst,
  input  logic [WenWidth*NrReq-1:0] req_wen,
  input  logic [NrReq-1:0]          req_lock,
  output logic [NrReq-1:0]          req_ready,
  output logic [InstWidth-1:0]      inst,
  output logic [WenWidth-1:0]       inst_en,
  output logic [NrReq-1:0]          grant,
  output logic                      lock_timeout
`ifdef OREG_ARBITER_STATS_EN
  ,
  output logic [7:0]                contention,
  output logic [3:0]                timeouts
`endif
);
  localparam int IW = $clog2(NrReq);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(LockTimeout - 1);
  state_e                r_state, w_state_nxt;
  logic [IW-1:0]         r_ptr, r_owner, w_idx;
  logic [CntWidth-1:0]   r_cnt, w_cnt_nxt;
  logic [NrReq-1:0]      w_valid, w_pick, r_grant;
  logic [InstWidth-1:0]  r_inst;
  logic [WenWidth-1:0]   r_inst_en;
  logic                  w_any, w_timeout, r_lock_timeout;
  // while locked only the owner's request reaches the picker
  assign w_valid = (r_state == LOCKED) ? (req_valid & (NrReq'(1) << r_owner)) : req_valid;
  rr_pick #(.N(NrReq)) u_pick (
    .i_valid  (w_valid),
    .i_pointer(r_ptr),
    .o_pick   (w_pick),
    .o_index  (w_idx),
    .o_any    (w_any)
  );
  assign req_ready    = w_pick & {NrReq{~reset}};
  // an owner transfer in the expiry cycle takes precedence over the timeout
  assign w_timeout    = (r_state == LOCKED) && !w_any && (r_cnt == CntMax);
  assign inst         = r_inst;
  assign inst_en      = r_inst_en;
  assign grant        = r_grant;
  assign lock_timeout = r_lock_timeout;
  always_comb begin
    w_state_nxt = w_any ? (req_lock[w_idx] ? LOCKED : UNLOCKED) : (w_timeout ? UNLOCKED : r_state);
    w_cnt_nxt   = (w_any || w_timeout || r_state == UNLOCKED) ? '0 : r_cnt + CntWidth'(1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= UNLOCKED;
    else r_state <= w_state_nxt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_ptr          <= IW'(NrReq - 1);
      r_owner        <= '0;
      r_cnt          <= '0;
      r_inst         <= '0;
      r_inst_en      <= '0;
      r_grant        <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_lock_timeout <= w_timeout;
      r_inst_en      <= w_any ? req_wen[WenWidth*w_idx +: WenWidth] : '0;
      if (w_any) begin
        r_ptr   <= w_idx;
        r_owner <= w_idx;
        r_inst  <= req_inst[InstWidth*w_idx +: InstWidth];
        r_grant <= w_pick;
      end
    end
`ifdef OREG_ARBITER_STATS_EN
  logic [7:0] r_contention;
  logic [3:0] r_timeouts;
  assign contention = r_contention;
  assign timeouts   = r_timeouts;
  // two or more valid bits always means someone is denied, since at most one is accepted
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_contention <= '0;
      r_timeouts   <= '0;
    end else begin
      if (((req_valid & (req_valid - NrReq'(1))) != '0) && r_contention != 8'hFF) r_contention <= r_contention + 8'd1;
      if (w_timeout && r_timeouts != 4'hF) r_timeouts <= r_timeouts + 4'd1;
    end
`endif
endmodule

// File: tb/tb_oreg_arbiter.sv
// tb_oreg_arbiter: randomized and directed checks of oreg_arbiter against a behavioural model
module tb_oreg_arbiter;
  localparam int N  = 2;
  localparam int LT = 4;
  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_lock, req_ready, grant;
  logic [12*N-1:0] req_inst;
  logic [8*N-1:0]  req_wen;
  logic [11:0]   inst;
  logic [7:0]    inst_en;
  logic          lock_timeout;
  int            n_tests = 0;
  int            n_fail = 0;
  int            m_ptr, m_owner, m_idle;
  logic [11:0]   e_inst;
  logic [7:0]    e_en;
  logic [N-1:0]  e_grant;
  logic          e_to;
  int            m_cont, m_touts;
`ifdef OREG_ARBITER_STATS_EN
  logic [7:0]    contention;
  logic [3:0]    timeouts;
`endif
  oreg_arbiter #(.NrReq(N), .LockTimeout(LT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_inst    (req_inst),
    .req_wen     (req_wen),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .inst        (inst),
    .inst_en     (inst_en),
    .grant       (grant),
    .lock_timeout(lock_timeout)
`ifdef OREG_ARBITER_STATS_EN
    ,
    .contention  (contention),
    .timeouts    (timeouts)
`endif
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ptr = N - 1;
    m_owner = -1;
    m_idle = 0;
    e_inst = '0;
    e_en = '0;
    e_grant = '0;
    e_to = 1'b0;
    m_cont = 0;
    m_touts = 0;
  endtask
  task automatic check_outs();
    check("inst", 32'(inst), 32'(e_inst));
    check("inst_en", 32'(inst_en), 32'(e_en));
    check("grant", 32'(grant), 32'(e_grant));
    check("lock_timeout", 32'(lock_timeout), 32'(e_to));
  endtask
  // one clock: drive, check the combinational ready, advance the model, check registered outputs
  task automatic cycle(input logic [N-1:0] v, input logic [12*N-1:0] ins, input logic [8*N-1:0] w, input logic [N-1:0] lk);
    int win;
    int cnt;
    req_valid = v;
    req_inst  = ins;
    req_wen   = w;
    req_lock  = lk;
    #1;
    win = -1;
    if (m_owner >= 0) begin
      if (v[m_owner]) win = m_owner;
    end else begin
      for (int k = 1; k <= N; k++)
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    check("req_ready", 32'(req_ready), (win < 0) ? 32'd0 : (32'd1 << win));
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(v[i]);
    if (cnt >= 2 && m_cont < 255) m_cont++;
    @(posedge clock);
    e_to = 1'b0;
    if (win >= 0) begin
      e_inst  = ins[12*win +: 12];
      e_en    = w[8*win +: 8];
      e_grant = N'(1) << win;
      m_ptr   = win;
      m_owner = lk[win] ? win : -1;
      m_idle  = 0;
    end else begin
      e_en = '0;
      if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == LT) begin
          m_owner = -1;
          m_idle  = 0;
          e_to    = 1'b1;
          if (m_touts < 15) m_touts++;
        end
      end
    end
    #1;
    check_outs();
  endtask
  task automatic rnd_cycle();
    logic [N-1:0] lk;
    logic [8*N-1:0] w;
    for (int i = 0; i < N; i++) begin
      lk[i] = ($urandom % 3) == 0;
      w[8*i +: 8] = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
    end
    cycle(N'($urandom_range(0, 3)), (12*N)'($urandom), w, lk);
  endtask
  task automatic do_reset();
    #3 reset = 1'b1;
    req_valid = '1;
    #1;
    model_reset();
    check("rst_ready", 32'(req_ready), 32'd0);
    check_outs();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_inst = '0;
    req_wen = '0;
    req_lock = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outs();
    check("init_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    // single transfer then idle
    cycle(2'b01, {12'h000, 12'h0A5}, {8'h00, 8'h01}, 2'b00);
    cycle(2'b00, {12'h111, 12'h222}, {8'hFF, 8'hFF}, 2'b00);
    // strict rotation under full contention
    for (int i = 0; i < 6; i++) cycle(2'b11, (12*N)'($urandom), {8'h02, 8'h04}, 2'b00);
    // req 1 locks, sends three locked transfers and a no-op release while req 0 waits
    cycle(2'b10, {12'h3C3, 12'h000}, {8'h10, 8'h00}, 2'b10);
    for (int i = 0; i < 3; i++) cycle(2'b11, (12*N)'($urandom), {8'h20, 8'h40}, 2'b10);
    cycle(2'b11, {12'h7E7, 12'h001}, {8'h00, 8'h80}, 2'b00);
    for (int i = 0; i < 6; i++) cycle(2'b01, (12*N)'($urandom), {8'h01, 8'h08}, 2'b00);
    // req 0 locks and goes idle: timeout after LT idle cycles, req 1 accepted next
    cycle(2'b01, {12'h000, 12'h5A5}, {8'h00, 8'h01}, 2'b01);
    for (int i = 0; i < LT + 1; i++) cycle(2'b10, (12*N)'($urandom), {8'h02, 8'h00}, 2'b00);
    // owner returns exactly on the expiry cycle: transfer wins, lock held
    cycle(2'b01, {12'h000, 12'h1F1}, {8'h00, 8'h04}, 2'b01);
    for (int i = 0; i < LT - 1; i++) cycle(2'b10, (12*N)'($urandom), {8'h02, 8'h00}, 2'b00);
    cycle(2'b11, {12'h0F0, 12'h2E2}, {8'h02, 8'h08}, 2'b01);
    cycle(2'b10, {12'h0F0, 12'h000}, {8'h02, 8'h00}, 2'b00);
    // reset while locked with traffic in flight
    cycle(2'b01, {12'h000, 12'h333}, {8'h00, 8'h01}, 2'b01);
    cycle(2'b11, {12'h444, 12'h555}, {8'h01, 8'h01}, 2'b01);
    do_reset();
    cycle(2'b11, {12'hABC, 12'h123}, {8'h01, 8'h02}, 2'b00);
    for (int i = 0; i < 400; i++) rnd_cycle();
`ifdef OREG_ARBITER_STATS_EN
    check("contention", 32'(contention), 32'(m_cont));
    check("timeouts", 32'(timeouts), 32'(m_touts));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
